// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: burst-oriented round-robin arbiter sharing one async-FIFO write port.
// Optional: define FIFO_WR_ARB_STALL_CNT_EN to add the saturating stall_cnt output.
module fifo_wr_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4,
  localparam int OW   = $clog2(NREQ),
  localparam int BW   = $clog2(BURST) + 1
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  input  logic                  wfull,
  output logic                  winc,
  output logic [WIDTH-1:0]      wdata,
  output logic [OW-1:0]         owner,
  output logic                  busy
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  // Handshake: req[i] is a level held with req_data[i] stable; gnt[i] acts as
  // ready, so a word is consumed on every clock edge where gnt[i] is high.

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [BW-1:0]   beat_q, beat_d, beat_inc;
  logic            accept;
  logic            found;
  logic [WIDTH-1:0] words [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign words[g] = req_data[g*WIDTH +: WIDTH];
  end

  assign accept   = (state_q == S_BURST) && req[owner_q] && !wfull;
  assign beat_inc = beat_q + BW'(1);

  // State register; owner resets to NREQ-1 so requester 0 wins first.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q <= S_IDLE;
      owner_q <= OW'(NREQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    found   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          // First requester strictly after the previous owner, wrapping.
          for (int i = 1; i <= NREQ; i++) begin
            logic [OW-1:0] cand;
            cand = OW'((int'(owner_q) + i) % NREQ);
            if (!found && req[cand]) begin
              owner_d = cand;
              found   = 1'b1;
            end
          end
          beat_d  = '0;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (!req[owner_q]) begin
          state_d = S_IDLE;
        end else if (accept) begin
          beat_d = beat_inc;
          if (beat_inc == BW'(BURST)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt   = '0;
    winc  = 1'b0;
    wdata = '0;
    if (accept) begin
      gnt[owner_q] = 1'b1;
      winc         = 1'b1;
      wdata        = words[owner_q];
    end
    busy  = (state_q == S_BURST);
    owner = owner_q;
  end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      stall_cnt <= '0;
    end else if ((state_q == S_BURST) && req[owner_q] && wfull &&
                 (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the async FIFO among NREQ requesters in the write-clock domain.
- Grants are burst-oriented: an owner keeps the port for up to BURST accepted words, then ownership rotates.
- Drives the FIFO winc/wdata and honours its wfull flag; the FIFO itself is unchanged.

Parameters:
- WIDTH, 8, data word width; must match the FIFO WIDTH.
- NREQ, 4, number of requesters, 2..8.
- BURST, 4, maximum words accepted per ownership, 1..16.

Ports:
- wclk  input  1  write-domain clock.
- wrst  input  1  asynchronous reset, active-high.
- req  input  NREQ  per-requester request; level, held while data is valid.
- req_data  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot accept strobe; gnt[i]=1 means req_data[i] is consumed this cycle.
- wfull  input  1  FIFO full flag.
- winc  output  1  FIFO write enable.
- wdata  output  WIDTH  FIFO write data.
- owner  output  clog2(NREQ)  current/last owner index.
- busy  output  1  high in BURST state.

Behaviour:
- Reset:
  - State = IDLE, owner = NREQ-1 so requester 0 wins first, and beat_cnt = 0.
  - gnt, winc, busy and wdata are 0 immediately on wrst assertion, with no clock needed.
- FSM states are IDLE and BURST.
- IDLE:
  - If any req bit is high, select the first set bit searching from owner+1 upward, modulo NREQ.
  - Load owner, clear beat_cnt, go to BURST on the next edge.
  - Arbitration latency is 1 cycle.
  - No grants are issued in IDLE.
- BURST, accept condition:
  - accept = req[owner] && !wfull.
  - On accept, gnt[owner] = 1, winc = 1 and wdata = req_data[owner], all combinational in the same cycle.
  - beat_cnt increments on each accept.
- BURST, exit:
  - Return to IDLE after the accept that brings beat_cnt to BURST.
  - Also return to IDLE on any cycle where req[owner] = 0, including before the first accept.
  - owner is retained as the round-robin pointer.
- BURST, stall:
  - If wfull = 1 with req[owner] = 1, stay in BURST, issue no grant, and leave beat_cnt unchanged.
  - A stall never ends a burst.
- Invariants:
  - At most one gnt bit is high per cycle.
  - winc equals OR of gnt.
  - winc is never high while wfull = 1, so no FIFO overflow is possible through this block.
- Fairness: with all requesters continuously active and wfull = 0, ownership order is 0,1,…,NREQ-1,0,…, each receiving exactly BURST words, with a 1-cycle IDLE gap between bursts.
- Requesters not owning the port see gnt = 0 and must hold req_data stable until granted.
- req rising or falling for a non-owner during BURST has no effect until the next IDLE.
- beat_cnt width is clog2(BURST)+1; no wrap is possible because BURST exits at count BURST.
- Reset mid-burst aborts the burst with no grant on that cycle. After release, arbitration restarts from requester 0.
- NREQ=1 is not supported.

Optional Feature:
- Macro: FIFO_WR_ARB_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [15:0], reset to 0 by wrst.
  - stall_cnt increments on every BURST cycle with req[owner] = 1 and wfull = 1.
  - It saturates at 16'hFFFF.
- When undefined: the port and logic are absent, and all other behaviour is identical.

Test Plan:
- Reset then single requester: req = 4'b0100 with data 8'hA0..A5 while wfull = 0. Expect IDLE for 1 cycle, then gnt = 4'b0100 for 4 consecutive cycles writing A0..A3, IDLE for 1 cycle, then a new burst to requester 2 writing A4, A5.
- All four requesting continuously, wfull = 0: expect the owner sequence 0,1,2,3,0 with 4 winc pulses each and a 1-cycle gap between bursts; 16 words are written in 20 cycles.
- Stall mid-burst: owner 1 after 2 accepts, wfull = 1 for 5 cycles. Expect gnt = 0 and winc = 0 during those 5 cycles, busy = 1, the remaining 2 words after wfull drops, and stall_cnt = 5 when the macro is defined.
- Early release: owner 3 drops req after 1 accept while req[0] = 1. Expect IDLE next cycle, then owner = 0.
- Async reset mid-burst: assert wrst between clock edges while owner 2 is in the 2nd beat. Expect gnt, winc and busy to go 0 immediately. After release with all req high, the first owner is 0.
- Full at first beat: wfull = 1 on entry to BURST for owner 0. Expect no winc until wfull = 0, then exactly 4 words written.
